// File: rtl/nios2_debug_ocimem_ctrl_pkg.sv
// nios2_debug_pkg: definitions shared by the debug OCI memory controller.
//   state_t    : controller state encoding.
//   JDO_*      : bit positions of the fields carried on the 38-bit jdo bus.
package nios2_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,  // free: accepts JTAG strobes and CPU requests
    ST_JRD  = 3'd1,  // JTAG read: RAM addressed with MonAReg
    ST_JCAP = 3'd2,  // JTAG read: capture RAM q into MonDReg
    ST_JWR  = 3'd3,  // JTAG write: RAM written at MonAReg
    ST_CRD  = 3'd4   // CPU read: RAM q presented on dm_readdata
  } state_t;

  localparam int JDO_RD_FLAG   = 34;
  localparam int JDO_ERRCLR    = 35;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/nios2_debug_ocimem_ctrl_if.sv
// nios2_debug_ocimem_ctrl_if: bundles the JTAG-wrapper side (jdo, strobes,
// MonDReg/MonAReg/monitor_ready/monitor_error) and the CPU slave port
// (dm_*) of the debug memory controller.
//   slave  : controller view (strobes and CPU requests in, results out).
//   master : wrapper/CPU view.
interface nios2_debug_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [31:0]       MonDReg;
  logic [ADDR_W-1:0] MonAReg;
  logic              monitor_ready;
  logic              monitor_error;
  logic [ADDR_W-1:0] dm_address;
  logic              dm_read;
  logic              dm_write;
  logic [31:0]       dm_writedata;
  logic [3:0]        dm_byteenable;
  logic [31:0]       dm_readdata;
  logic              dm_waitrequest;

  modport slave (
    input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    input  dm_address, dm_read, dm_write, dm_writedata, dm_byteenable,
    output MonDReg, MonAReg, monitor_ready, monitor_error,
    output dm_readdata, dm_waitrequest
  );

  modport master (
    output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    output dm_address, dm_read, dm_write, dm_writedata, dm_byteenable,
    input  MonDReg, MonAReg, monitor_ready, monitor_error,
    input  dm_readdata, dm_waitrequest
  );
endinterface

// File: rtl/nios2_debug_ocimem_ctrl_ram.sv
// nios2_debug_ocimem_ram: single-port synchronous RAM, DEPTH x 32, with
// per-byte write enables and one cycle of read latency. Contents are never
// reset.
//   clk     : clock
//   i_addr  : word address
//   i_we    : write enable
//   i_be    : byte enables for the write
//   i_wdata : write data
//   o_q     : registered read data of the word addressed last cycle
module nios2_debug_ocimem_ram #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_q
);

  // One byte-wide array per lane keeps each array single-writer and maps
  // onto block RAM byte-write enables.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
      if (i_we && i_be[gi]) begin
        r_mem[i_addr] <= i_wdata[8*gi +: 8];
      end
      r_q <= r_mem[i_addr];
    end

    assign o_q[8*gi +: 8] = r_q;
  end

endmodule

// File: rtl/nios2_debug_ocimem_ctrl.sv
// nios2_debug_ocimem_ctrl: sysclk-domain debug memory controller. Executes
// JTAG word reads/writes (via jdo and the ocimem strobes) on a local RAM
// and arbitrates a CPU slave port onto the same RAM, JTAG first.
//   clk     : system clock
//   reset_n : synchronous active-low reset (RAM contents are kept)
//   dbg     : slave side of the wrapper/CPU bus interface
module nios2_debug_ocimem_ctrl
  import nios2_debug_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                        clk,
  input  logic                        reset_n,
  nios2_debug_ocimem_ctrl_if.slave    dbg
);

  state_t            r_state;
  logic [31:0]       r_mon_d;
  logic [ADDR_W-1:0] r_mon_a;
  logic              r_ready;
  logic              r_error;
  logic              r_ready_pend;  // address-only load: raise ready one cycle later
  logic [31:0]       r_wdata;

  logic              w_jtag_any;
  logic              w_idle;
  logic              w_cpu_wr;
  logic              w_jtag_acc;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;
  logic [3:0]        w_ram_be;
  logic [31:0]       w_ram_wdata;
  logic [31:0]       w_ram_q;
  logic              w_unused;

  assign w_jtag_any = dbg.take_action_ocimem_a | dbg.take_action_ocimem_b |
                      dbg.take_no_action_ocimem_a;
  assign w_idle     = (r_state == ST_IDLE);
  // A CPU write is only taken in a free cycle; a concurrent read wins.
  assign w_cpu_wr   = w_idle && !w_jtag_any && dbg.dm_write && !dbg.dm_read;
  assign w_jtag_acc = (r_state == ST_JRD) || (r_state == ST_JWR);

  // In IDLE the RAM is addressed by the CPU so that a granted read has its
  // data ready in the following CRD cycle.
  assign w_ram_addr  = w_jtag_acc ? r_mon_a : dbg.dm_address;
  // Gated by reset_n so an aborted op never commits a write.
  assign w_ram_we    = reset_n && ((r_state == ST_JWR) || w_cpu_wr);
  assign w_ram_be    = (r_state == ST_JWR) ? 4'hF : dbg.dm_byteenable;
  assign w_ram_wdata = (r_state == ST_JWR) ? r_wdata : dbg.dm_writedata;

  nios2_debug_ocimem_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_be    (w_ram_be),
    .i_wdata (w_ram_wdata),
    .o_q     (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_mon_d      <= '0;
      r_mon_a      <= '0;
      r_ready      <= 1'b0;
      r_error      <= 1'b0;
      r_ready_pend <= 1'b0;
      r_wdata      <= '0;
    end else begin
      if (r_ready_pend) begin
        r_ready      <= 1'b1;
        r_ready_pend <= 1'b0;
      end
      if (w_jtag_any && !w_idle) begin
        r_error <= 1'b1;  // command dropped; in-flight op continues
      end

      case (r_state)
        ST_IDLE: begin
          if (dbg.take_action_ocimem_a) begin
            r_mon_a <= dbg.jdo[JDO_ADDR_LSB +: ADDR_W];
            r_ready <= 1'b0;
            if (dbg.jdo[JDO_ERRCLR]) begin
              r_error <= 1'b0;
            end
            if (dbg.jdo[JDO_RD_FLAG]) begin
              r_ready_pend <= 1'b0;
              r_state      <= ST_JRD;
            end else begin
              r_ready_pend <= 1'b1;
            end
          end else if (dbg.take_action_ocimem_b) begin
            r_wdata      <= dbg.jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
            r_ready      <= 1'b0;
            r_ready_pend <= 1'b0;
            r_state      <= ST_JWR;
          end else if (dbg.take_no_action_ocimem_a) begin
            r_ready      <= 1'b0;
            r_ready_pend <= 1'b0;
            r_state      <= ST_JRD;
          end else if (dbg.dm_read) begin
            r_state <= ST_CRD;
          end
        end
        ST_JRD: r_state <= ST_JCAP;
        ST_JCAP: begin
          r_mon_d <= w_ram_q;
          r_mon_a <= r_mon_a + ADDR_W'(1);
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        ST_JWR: begin
          r_mon_a <= r_mon_a + ADDR_W'(1);
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        ST_CRD:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dbg.MonDReg        = r_mon_d;
  assign dbg.MonAReg        = r_mon_a;
  assign dbg.monitor_ready  = r_ready;
  assign dbg.monitor_error  = r_error;
  assign dbg.dm_readdata    = (r_state == ST_CRD) ? w_ram_q : 32'd0;
  assign dbg.dm_waitrequest = !((r_state == ST_CRD) || w_cpu_wr);

  // jdo bits with no meaning for this controller.
  assign w_unused = ^{dbg.jdo[37:36], dbg.jdo[2:0]};

endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// Self-checking bench for nios2_debug_ocimem_ctrl: directed scenarios plus a
// randomized mix of JTAG and CPU operations checked against a word-array
// model of the RAM and of the JTAG address/error registers.
module tb_nios2_debug_ocimem_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  nios2_debug_ocimem_ctrl_if #(.ADDR_W(8)) dbg();

  nios2_debug_ocimem_ctrl #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dbg     (dbg)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] ram_m [256];
  logic [7:0]  m_a;
  logic        m_err;
  logic [37:0] j_tmp;
  logic [7:0]  rnd_a;
  logic [31:0] rnd_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] rand_jdo();
    return {6'($urandom), $urandom};
  endfunction

  // ocimem_a: load address, optionally read; 'others' also raises the
  // lower-priority strobes, which must be ignored.
  task automatic jtag_a(input logic [7:0] addr, input bit rd, input bit clr, input bit others);
    logic [37:0] j;
    j = rand_jdo();
    j[24:17] = addr;
    j[34] = rd;
    j[35] = clr;
    dbg.jdo = j;
    dbg.take_action_ocimem_a = 1'b1;
    dbg.take_action_ocimem_b = others;
    dbg.take_no_action_ocimem_a = others;
    tick;
    dbg.take_action_ocimem_a = 1'b0;
    dbg.take_action_ocimem_b = 1'b0;
    dbg.take_no_action_ocimem_a = 1'b0;
    check("a_ready_low", 32'(dbg.monitor_ready), 32'd0);
    if (clr) m_err = 1'b0;
    if (rd) begin
      tick;
      check("a_rd_ready_t2", 32'(dbg.monitor_ready), 32'd0);
      tick;
      check("a_rd_ready_t3", 32'(dbg.monitor_ready), 32'd1);
      check("a_rd_data", dbg.MonDReg, ram_m[addr]);
      m_a = addr + 8'd1;
    end else begin
      tick;
      check("a_ready_t2", 32'(dbg.monitor_ready), 32'd1);
      m_a = addr;
    end
    check("a_monareg", 32'(dbg.MonAReg), 32'(m_a));
    check("a_error", 32'(dbg.monitor_error), 32'(m_err));
  endtask

  task automatic jtag_b(input logic [31:0] d);
    logic [37:0] j;
    j = rand_jdo();
    j[34:3] = d;
    dbg.jdo = j;
    dbg.take_action_ocimem_b = 1'b1;
    tick;
    dbg.take_action_ocimem_b = 1'b0;
    check("b_ready_low", 32'(dbg.monitor_ready), 32'd0);
    tick;
    check("b_ready_t2", 32'(dbg.monitor_ready), 32'd1);
    ram_m[m_a] = d;
    m_a = m_a + 8'd1;
    check("b_monareg", 32'(dbg.MonAReg), 32'(m_a));
  endtask

  task automatic jtag_na;
    dbg.jdo = rand_jdo();
    dbg.take_no_action_ocimem_a = 1'b1;
    tick;
    dbg.take_no_action_ocimem_a = 1'b0;
    check("na_ready_t1", 32'(dbg.monitor_ready), 32'd0);
    tick;
    check("na_ready_t2", 32'(dbg.monitor_ready), 32'd0);
    tick;
    check("na_ready_t3", 32'(dbg.monitor_ready), 32'd1);
    check("na_data", dbg.MonDReg, ram_m[m_a]);
    m_a = m_a + 8'd1;
    check("na_monareg", 32'(dbg.MonAReg), 32'(m_a));
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] be);
    dbg.dm_address = addr;
    dbg.dm_writedata = d;
    dbg.dm_byteenable = be;
    dbg.dm_write = 1'b1;
    #1;
    check("cw_wait", 32'(dbg.dm_waitrequest), 32'd0);
    tick;
    dbg.dm_write = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) ram_m[addr][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // CPU read, optionally with dm_write also high (the write must be ignored).
  task automatic cpu_read(input logic [7:0] addr, input bit with_wr);
    int n;
    dbg.dm_address = addr;
    dbg.dm_read = 1'b1;
    dbg.dm_write = with_wr;
    dbg.dm_writedata = $urandom;
    dbg.dm_byteenable = 4'hF;
    #1;
    check("cr_wait_req", 32'(dbg.dm_waitrequest), 32'd1);
    n = 0;
    do begin
      tick;
      n++;
    end while (dbg.dm_waitrequest && n < 8);
    check("cr_grant_cycles", 32'(n), 32'd1);
    check("cr_data", dbg.dm_readdata, ram_m[addr]);
    dbg.dm_read = 1'b0;
    dbg.dm_write = 1'b0;
    tick;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    dbg.jdo = '0;
    dbg.take_action_ocimem_a = 1'b0;
    dbg.take_action_ocimem_b = 1'b0;
    dbg.take_no_action_ocimem_a = 1'b0;
    dbg.dm_address = '0;
    dbg.dm_read = 1'b0;
    dbg.dm_write = 1'b0;
    dbg.dm_writedata = '0;
    dbg.dm_byteenable = '0;
    m_a = 8'd0;
    m_err = 1'b0;

    // Reset state.
    repeat (2) tick;
    check("rst_mondreg", dbg.MonDReg, 32'd0);
    check("rst_monareg", 32'(dbg.MonAReg), 32'd0);
    check("rst_ready", 32'(dbg.monitor_ready), 32'd0);
    check("rst_error", 32'(dbg.monitor_error), 32'd0);
    check("rst_readdata", dbg.dm_readdata, 32'd0);
    check("rst_wait", 32'(dbg.dm_waitrequest), 32'd1);
    reset_n = 1'b1;
    tick;

    // Fill every word through JTAG auto-increment; MonAReg wraps back to 0.
    jtag_a(8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) jtag_b($urandom);
    check("fill_wrap", 32'(dbg.MonAReg), 32'd0);

    // Address-only load.
    jtag_a(8'h10, 1'b0, 1'b0, 1'b0);
    // Write then read back.
    jtag_b(32'hDEADBEEF);
    jtag_a(8'h10, 1'b1, 1'b0, 1'b0);
    check("deadbeef", dbg.MonDReg, 32'hDEADBEEF);
    check("deadbeef_a", 32'(dbg.MonAReg), 32'h11);

    // Read at the top word wraps MonAReg.
    jtag_a(8'hFF, 1'b0, 1'b0, 1'b0);
    jtag_na;
    check("wrap_ff", 32'(dbg.MonAReg), 32'd0);

    // Strobe while busy is dropped and flags an error.
    jtag_a(8'h20, 1'b0, 1'b0, 1'b0);
    dbg.jdo = rand_jdo();
    dbg.take_no_action_ocimem_a = 1'b1;
    tick;
    dbg.take_no_action_ocimem_a = 1'b0;
    j_tmp = rand_jdo();
    j_tmp[34:3] = 32'h55555555;
    dbg.jdo = j_tmp;
    dbg.take_action_ocimem_b = 1'b1;
    check("drop_ready_t1", 32'(dbg.monitor_ready), 32'd0);
    tick;
    dbg.take_action_ocimem_b = 1'b0;
    check("drop_error", 32'(dbg.monitor_error), 32'd1);
    m_err = 1'b1;
    tick;
    check("drop_ready_t3", 32'(dbg.monitor_ready), 32'd1);
    check("drop_rd_data", dbg.MonDReg, ram_m[8'h20]);
    check("drop_monareg", 32'(dbg.MonAReg), 32'h21);
    jtag_a(8'h20, 1'b1, 1'b0, 1'b0);
    jtag_a(8'h21, 1'b1, 1'b0, 1'b0);
    jtag_a(8'h20, 1'b0, 1'b1, 1'b0);
    check("err_cleared", 32'(dbg.monitor_error), 32'd0);

    // CPU partial write over a known word.
    jtag_a(8'h05, 1'b0, 1'b0, 1'b0);
    jtag_b(32'hAAAAAAAA);
    cpu_write(8'h05, 32'h12345678, 4'b0011);
    cpu_read(8'h05, 1'b0);
    check("cpu_merge", ram_m[8'h05], 32'hAAAA5678);

    // CPU read colliding with a JTAG read: JTAG first.
    jtag_a(8'h30, 1'b0, 1'b0, 1'b0);
    dbg.dm_address = 8'h40;
    dbg.dm_read = 1'b1;
    dbg.take_no_action_ocimem_a = 1'b1;
    #1;
    check("col_wait_t0", 32'(dbg.dm_waitrequest), 32'd1);
    tick;
    dbg.take_no_action_ocimem_a = 1'b0;
    check("col_ready_t1", 32'(dbg.monitor_ready), 32'd0);
    check("col_wait_t1", 32'(dbg.dm_waitrequest), 32'd1);
    tick;
    check("col_wait_t2", 32'(dbg.dm_waitrequest), 32'd1);
    tick;
    check("col_ready_t3", 32'(dbg.monitor_ready), 32'd1);
    check("col_jdata", dbg.MonDReg, ram_m[8'h30]);
    check("col_wait_t3", 32'(dbg.dm_waitrequest), 32'd1);
    m_a = 8'h31;
    tick;
    check("col_wait_t4", 32'(dbg.dm_waitrequest), 32'd0);
    check("col_cdata", dbg.dm_readdata, ram_m[8'h40]);
    dbg.dm_read = 1'b0;
    tick;

    // Reset during a JTAG write aborts it.
    jtag_a(8'h50, 1'b0, 1'b0, 1'b0);
    j_tmp = rand_jdo();
    j_tmp[34:3] = ~ram_m[8'h50];
    dbg.jdo = j_tmp;
    dbg.take_action_ocimem_b = 1'b1;
    tick;
    dbg.take_action_ocimem_b = 1'b0;
    reset_n = 1'b0;
    tick;
    check("rwr_mondreg", dbg.MonDReg, 32'd0);
    check("rwr_monareg", 32'(dbg.MonAReg), 32'd0);
    check("rwr_ready", 32'(dbg.monitor_ready), 32'd0);
    check("rwr_error", 32'(dbg.monitor_error), 32'd0);
    check("rwr_readdata", dbg.dm_readdata, 32'd0);
    reset_n = 1'b1;
    m_a = 8'd0;
    m_err = 1'b0;
    tick;
    jtag_a(8'h50, 1'b1, 1'b0, 1'b0);

    // Randomized mix.
    for (int i = 0; i < 80; i++) begin
      rnd_a = 8'($urandom);
      rnd_d = $urandom;
      case ($urandom_range(0, 4))
        0: jtag_a(rnd_a, 1'($urandom), 1'($urandom), 1'($urandom));
        1: jtag_b(rnd_d);
        2: jtag_na;
        3: cpu_write(rnd_a, rnd_d, 4'($urandom));
        default: cpu_read(rnd_a, 1'($urandom));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nios2_debug_ocimem_ctrl.md
Name: nios2_debug_ocimem_ctrl

Overview:
- Sysclk-domain debug memory controller downstream of the debug-slave JTAG wrapper.
- Consumes the wrapper's jdo bus and take_action_ocimem_a, take_action_ocimem_b and take_no_action_ocimem_a strobes.
- Performs word reads and writes on a local debug/monitor RAM.
- Returns MonDReg, monitor_ready and monitor_error to the wrapper; also arbitrates a CPU-side slave port onto the same RAM.

Parameters:
- ADDR_W, 8, RAM word-address width; legal range 1..17.
- DEPTH, 256, RAM depth in words; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low.
- jdo  in  38  JTAG data-out from the debug slave.
- take_action_ocimem_a  in  1  one-cycle strobe: load address, optional read.
- take_action_ocimem_b  in  1  one-cycle strobe: write jdo[34:3] at MonAReg.
- take_no_action_ocimem_a  in  1  one-cycle strobe: read at MonAReg.
- MonDReg  out  32  last JTAG read data.
- MonAReg  out  ADDR_W  current JTAG word address.
- monitor_ready  out  1  JTAG op complete, controller idle.
- monitor_error  out  1  sticky: command dropped while busy.
- dm_address  in  ADDR_W  CPU word address.
- dm_read  in  1  CPU read request.
- dm_write  in  1  CPU write request.
- dm_writedata  in  32  CPU write data.
- dm_byteenable  in  4  CPU byte enables.
- dm_readdata  out  32  CPU read data.
- dm_waitrequest  out  1  CPU stall.

Behaviour:
- Reset (sync, reset_n=0 at a clk edge) takes effect in that cycle:
  - outputs: MonDReg=0, MonAReg=0, monitor_ready=0, monitor_error=0, dm_readdata=0; state=IDLE; pending command cleared.
  - RAM contents are not cleared.
  - reset during any state aborts the op; no partial write is committed after reset.
- Strobe priority when several arrive in one cycle: ocimem_a > ocimem_b > no_action_ocimem_a; lower-priority strobes are discarded silently.
- ocimem_a:
  - MonAReg <= jdo[17+ADDR_W-1:17].
  - jdo[35]=1 clears monitor_error.
  - jdo[34]=1 also starts a read at the new address; otherwise no RAM access and monitor_ready=1 next cycle.
- ocimem_b: write jdo[34:3] (all bytes) at MonAReg, then MonAReg+1.
- no_action_ocimem_a: read at MonAReg, then MonAReg+1.
- MonAReg increment wraps modulo 2**ADDR_W.
- States: IDLE, JRD, JCAP, JWR, CRD.
  - IDLE: a JTAG strobe goes to JRD (read) or JWR (write). Otherwise dm_read goes to CRD; otherwise dm_write is served in place.
  - JRD (T+1): RAM read at MonAReg; next state JCAP.
  - JCAP (T+2): MonDReg <= RAM q; post-increment applied; next state IDLE.
  - JWR (T+1): RAM write; post-increment; next state IDLE.
  - CRD: RAM q presented on dm_readdata; dm_waitrequest=0 this cycle; next state IDLE.
- JTAG latency, strobe at cycle T:
  - monitor_ready=0 from T+1.
  - Read: MonDReg valid and monitor_ready=1 at T+3.
  - Write: monitor_ready=1 at T+2.
- A JTAG strobe arriving while state!=IDLE: command dropped, monitor_error<=1 next cycle, in-flight op unaffected.
- CPU read: dm_waitrequest=1 in the request cycle, including when granted from IDLE. dm_readdata is valid in the CRD cycle with dm_waitrequest=0.
- CPU write: accepted (dm_waitrequest=0) in a cycle that is IDLE with no JTAG strobe; bytes written per dm_byteenable.
- JTAG strobe and CPU request in the same IDLE cycle: JTAG wins; CPU sees dm_waitrequest=1 and retries next IDLE.
- dm_read and dm_write both high: read served, write ignored.
- The CPU must hold its request until dm_waitrequest=0.

Decomposition:
- Shared package nios2_debug_pkg holds:
  - state enum.
  - jdo field constants: JDO_RD_FLAG=34, JDO_ERRCLR=35, JDO_ADDR_LSB=17, JDO_WDATA_MSB=34, JDO_WDATA_LSB=3.
- One sub-module, nios2_debug_ocimem_ram: single-port synchronous RAM, DEPTH x 32, byte enables, 1-cycle read latency.

Test Plan:
- Reset, then ocimem_a with jdo[24:17]=0x10 and jdo[34]=0 → MonAReg=0x10, monitor_ready=1 at T+2, no RAM access.
- ocimem_b with jdo[34:3]=0xDEADBEEF at MonAReg=0x10, then ocimem_a with address 0x10 and jdo[34]=1 → MonDReg=0xDEADBEEF at T+3; MonAReg=0x11.
- MonAReg=0xFF, no_action_ocimem_a → read of word 0xFF, MonAReg wraps to 0x00.
- no_action_ocimem_a at T, ocimem_b at T+1 → monitor_error=1 at T+2; write not performed; then ocimem_a with jdo[35]=1 → monitor_error=0.
- CPU write 0x12345678 with byteenable=4'b0011 to addr 5 over prior 0xAAAAAAAA, then CPU read addr 5 → dm_readdata=0xAAAA5678 in the dm_waitrequest=0 cycle.
- dm_read asserted in the same cycle as no_action_ocimem_a → JTAG completes first; CPU dm_waitrequest held high until CRD; reset_n=0 during JWR → RAM word unchanged, all outputs 0 next cycle.
